wave_phase_engine: RTL

WAVE_PHASE_ENGINE -- requirements
Module: wave_phase_engine

---
 rtl/wave_phase_engine.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wave_phase_engine.sv
// Animated sine-wave engine: per-channel phase accumulators advanced on frame_tick, plus a 2-stage pixel hit test.
// Optional mirrored second wave (double-sine band) enabled by `define WAVE_PHASE_ENGINE_MIRROR_EN.
module wave_phase_engine #(
  parameter int CHANNELS = 2,
  parameter int LUT_LOG2 = 4,
  parameter int PHASE_W  = 10,
  parameter int X_SHIFT  = 3,
  parameter int THICK    = 3,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               cfg_we,
  input  logic [CW-1:0]      cfg_ch,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic               cfg_dir,
  input  logic               cfg_pause,
  input  logic               cfg_clr,
  input  logic [9:0]         cfg_base_y,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [CW-1:0]      pix_ch,
  output logic               out_valid,
  output logic               draw,
  output logic [7:0]         sample
);

  localparam int D = 1 << LUT_LOG2;

  // floor(128 + 127*sin(2*pi*i/D)) in Q30 fixed point; quadrant folding keeps the exact points exact.
  function automatic logic [7:0] lut_entry(input int i);
    longint x;
    longint term;
    longint sum;
    longint mag;
    int     quad;
    int     rem;
    int     ang;
    quad = (4 * i) / D;
    rem  = (4 * i) % D;
    ang  = quad[0] ? (D - rem) : rem;
    if (ang == 0) begin
      sum = 64'sd0;
    end else if (ang == D) begin
      sum = 64'sd1 <<< 30;
    end else begin
      x    = (64'sd3373259426 * longint'(ang)) / longint'(2 * D);
      term = x;
      sum  = x;
      for (int k = 1; k <= 8; k++) begin
        term = -((((term * x) >>> 30) * x) >>> 30) / longint'(2 * k * (2 * k + 1));
        sum  = sum + term;
      end
    end
    mag = 64'sd127 * sum;
    if (quad < 2) begin
      lut_entry = 8'(64'sd128 + (mag >>> 30));
    end else begin
      lut_entry = 8'(64'sd128 - ((mag + (64'sd1 <<< 30) - 64'sd1) >>> 30));
    end
  endfunction

  logic [7:0] lut_s [D];
  for (genvar g = 0; g < D; g++) begin : g_lut
    localparam logic [7:0] ENTRY = lut_entry(g);
    assign lut_s[g] = ENTRY;
  end

  logic [PHASE_W-1:0] phase_r     [CHANNELS];
  logic [PHASE_W-1:0] step_r      [CHANNELS];
  logic [9:0]         base_y_r    [CHANNELS];
  logic [PHASE_W-1:0] phase_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] dir_r;
  logic [CHANNELS-1:0] pause_r;
  logic               cfg_hit_s;

  // Next phase: a clear wins; otherwise the tick uses the settings held before any same-cycle write.
  always_comb begin
    cfg_hit_s = cfg_we && (32'(cfg_ch) < CHANNELS);
    for (int c = 0; c < CHANNELS; c++) begin
      if (cfg_hit_s && cfg_clr && (cfg_ch == CW'(c))) begin
        phase_nxt_s[c] = {PHASE_W{1'b0}};
      end else if (frame_tick && !pause_r[c]) begin
        phase_nxt_s[c] = dir_r[c] ? (phase_r[c] - step_r[c]) : (phase_r[c] + step_r[c]);
      end else begin
        phase_nxt_s[c] = phase_r[c];
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_r[c]  <= {PHASE_W{1'b0}};
        step_r[c]   <= {PHASE_W{1'b0}};
        base_y_r[c] <= 10'd0;
      end
      dir_r   <= {CHANNELS{1'b0}};
      pause_r <= {CHANNELS{1'b0}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_r[c] <= phase_nxt_s[c];
        if (cfg_hit_s && (cfg_ch == CW'(c))) begin
          step_r[c]   <= cfg_step;
          dir_r[c]    <= cfg_dir;
          pause_r[c]  <= cfg_pause;
          base_y_r[c] <= cfg_base_y;
        end
      end
    end
  end

  logic                ch_ok_s;
  logic [CW-1:0]       sel_ch_s;
  logic [9:0]          xs_s;
  logic [LUT_LOG2-1:0] idx_s;

  // Stage-0 table index from the column and the channel's current (pre-tick) phase.
  always_comb begin
    ch_ok_s = 32'(pix_ch) < CHANNELS;
    if (ch_ok_s) begin
      sel_ch_s = pix_ch;
    end else begin
      sel_ch_s = {CW{1'b0}};
    end
    xs_s  = pix_x >> X_SHIFT;
    idx_s = LUT_LOG2'(xs_s) + phase_r[sel_ch_s][PHASE_W-1 -: LUT_LOG2];
  end

  logic       v1_r;
  logic       ok1_r;
  logic [7:0] samp1_r;
  logic [9:0] y1_r;
  logic [9:0] base1_r;

  // Stage 1: capture the looked-up value, row and band origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      ok1_r   <= 1'b0;
      samp1_r <= 8'd0;
      y1_r    <= 10'd0;
      base1_r <= 10'd0;
    end else begin
      v1_r <= pix_valid;
      if (pix_valid) begin
        ok1_r   <= ch_ok_s;
        samp1_r <= lut_s[idx_s];
        y1_r    <= pix_y;
        base1_r <= base_y_r[sel_ch_s];
      end
    end
  end

  logic [7:0]  inv_s;
  logic [10:0] y11_s;
  logic [10:0] y_wave_s;
  logic        hit_s;
`ifdef WAVE_PHASE_ENGINE_MIRROR_EN
  logic [10:0] y_mir_s;
`endif

  // Band test in 11 bits so a band running past row 1023 cannot wrap back to the top.
  always_comb begin
    inv_s    = ~samp1_r;
    y11_s    = {1'b0, y1_r};
    y_wave_s = {1'b0, base1_r} + {5'd0, inv_s[7:2]};
    hit_s    = (y11_s >= y_wave_s) && (y11_s < (y_wave_s + 11'(THICK)));
`ifdef WAVE_PHASE_ENGINE_MIRROR_EN
    y_mir_s  = {1'b0, base1_r} + {5'd0, samp1_r[7:2]};
    hit_s    = hit_s || ((y11_s >= y_mir_s) && (y11_s < (y_mir_s + 11'(THICK))));
`endif
  end

  logic       out_valid_r;
  logic       draw_r;
  logic [7:0] sample_r;

  // Stage 2: result registers; data holds while no result is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      draw_r      <= 1'b0;
      sample_r    <= 8'd0;
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        draw_r   <= ok1_r && hit_s;
        sample_r <= samp1_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign draw      = draw_r;
  assign sample    = sample_r;

endmodule
